// File: rtl/bus_pkg.sv
// Shared types and default constants for the 8088 minimum-mode bus cycle controller.
package bus_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        ADDR   = 4'b0010,
        STROBE = 4'b0100,
        HOLD   = 4'b1000
    } bus_state_t;

    localparam int WAIT_W = 4;

    localparam logic [19:0] DEF_MEM_BASE = 20'h00000;
    localparam logic [19:0] DEF_MEM_MASK = 20'h80000;
    localparam logic [15:0] DEF_IO_BASE  = 16'h0080;
    localparam logic [15:0] DEF_IO_MASK  = 16'hFFF0;

endpackage

// File: rtl/bus_region_decode.sv
// Combinational decode of a latched bus address into memory / I/O region hits.
module bus_region_decode
    import bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 20,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = DEF_MEM_BASE,
    parameter logic [ADDR_WIDTH-1:0] MEM_MASK   = DEF_MEM_MASK,
    parameter logic [15:0]           IO_BASE    = DEF_IO_BASE,
    parameter logic [15:0]           IO_MASK    = DEF_IO_MASK
) (
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  IOM,
    output logic                  mem_hit,
    output logic                  io_hit
);

    // IOM picks the space, so the two hits can never be true together.
    assign mem_hit = !IOM && ((Address & MEM_MASK) == MEM_BASE);
    assign io_hit  =  IOM && ((Address[15:0] & IO_MASK) == IO_BASE);

endmodule

// File: rtl/bus_cycle_controller.sv
// 8088 minimum-mode bus front end: address latch, region chip selects, strobes and wait states.
// Optional build macro BUS_TIMEOUT_EN adds an ADDR-state timeout and the BusErr pulse.
module bus_cycle_controller
    import bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 20,
    parameter int                    NUM_WAIT   = 2,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = DEF_MEM_BASE,
    parameter logic [ADDR_WIDTH-1:0] MEM_MASK   = DEF_MEM_MASK,
    parameter logic [15:0]           IO_BASE    = DEF_IO_BASE,
    parameter logic [15:0]           IO_MASK    = DEF_IO_MASK
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ALE,
    input  logic                    IOM_in,
    input  logic                    RD_n,
    input  logic                    WR_n,
    input  logic [ADDR_WIDTH-9:0]   A_hi,
    input  logic [7:0]              AD,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic                    IOM,
    output logic                    MemCS,
    output logic                    IoCS,
    output logic                    OE,
    output logic                    WR,
    output logic                    READY,
    output logic                    BusErr
);

    localparam logic [WAIT_W-1:0] LP_NUM_WAIT = WAIT_W'(NUM_WAIT);

    bus_state_t             r_state;
    bus_state_t             w_nextState;
    logic [ADDR_WIDTH-1:0]  r_address;
    logic                   r_iom;
    logic                   r_memCs;
    logic                   r_ioCs;
    logic                   r_oe;
    logic                   r_wr;
    logic                   r_ready;
    logic [WAIT_W-1:0]      r_waitCnt;

    logic [ADDR_WIDTH-1:0]  w_addressNxt;
    logic                   w_iomNxt;
    logic                   w_memCsNxt;
    logic                   w_ioCsNxt;
    logic                   w_oeNxt;
    logic                   w_wrNxt;
    logic                   w_readyNxt;
    logic [WAIT_W-1:0]      w_waitCntNxt;
    logic                   w_busErrNxt;

    logic                   w_memHit;
    logic                   w_ioHit;
    logic                   w_rdReq;
    logic                   w_wrReq;
    logic                   w_violation;
    logic                   w_timeout;

    assign w_rdReq     = !RD_n &&  WR_n;
    assign w_wrReq     =  RD_n && !WR_n;
    assign w_violation = !RD_n && !WR_n;

    bus_region_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_BASE   (MEM_BASE),
        .MEM_MASK   (MEM_MASK),
        .IO_BASE    (IO_BASE),
        .IO_MASK    (IO_MASK)
    ) u_decode (
        .Address (r_address),
        .IOM     (r_iom),
        .mem_hit (w_memHit),
        .io_hit  (w_ioHit)
    );

`ifdef BUS_TIMEOUT_EN
    logic [7:0] r_toCnt;
    logic       r_busErr;

    // 255 cycles parked in ADDR without ALE or a strobe abandon the cycle.
    assign w_timeout = (r_toCnt == 8'd254);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_toCnt  <= '0;
            r_busErr <= 1'b0;
        end else begin
            r_busErr <= w_busErrNxt;
            if (r_state == ADDR && w_nextState == ADDR && !ALE)
                r_toCnt <= r_toCnt + 8'd1;
            else
                r_toCnt <= '0;
        end
    end

    assign BusErr = r_busErr;
`else
    assign w_timeout = 1'b0;
    assign BusErr    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_address <= '0;
            r_iom     <= 1'b0;
            r_memCs   <= 1'b0;
            r_ioCs    <= 1'b0;
            r_oe      <= 1'b1;
            r_wr      <= 1'b1;
            r_ready   <= 1'b1;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_address <= w_addressNxt;
            r_iom     <= w_iomNxt;
            r_memCs   <= w_memCsNxt;
            r_ioCs    <= w_ioCsNxt;
            r_oe      <= w_oeNxt;
            r_wr      <= w_wrNxt;
            r_ready   <= w_readyNxt;
            r_waitCnt <= w_waitCntNxt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (ALE) w_nextState = ADDR;
            ADDR: begin
                if (ALE)                         w_nextState = ADDR;
                else if (w_rdReq || w_wrReq)     w_nextState = STROBE;
                else if (w_violation || w_timeout) w_nextState = IDLE;
            end
            STROBE:  if (r_waitCnt == WAIT_W'(1)) w_nextState = HOLD;
            HOLD:    if (RD_n && WR_n) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Next values of every registered output; chip selects come from the decode of the latched address.
    always_comb begin
        w_addressNxt = r_address;
        w_iomNxt     = r_iom;
        w_memCsNxt   = r_memCs;
        w_ioCsNxt    = r_ioCs;
        w_oeNxt      = r_oe;
        w_wrNxt      = r_wr;
        w_readyNxt   = r_ready;
        w_waitCntNxt = r_waitCnt;
        w_busErrNxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (ALE) begin
                    w_addressNxt = {A_hi, AD};
                    w_iomNxt     = IOM_in;
                end
            end
            ADDR: begin
                if (ALE) begin
                    w_addressNxt = {A_hi, AD};
                    w_iomNxt     = IOM_in;
                end else if (w_rdReq || w_wrReq) begin
                    w_oeNxt      = !w_rdReq;
                    w_wrNxt      = !w_wrReq;
                    w_memCsNxt   = w_memHit;
                    w_ioCsNxt    = w_ioHit;
                    w_readyNxt   = 1'b0;
                    w_waitCntNxt = LP_NUM_WAIT;
                end else if (w_violation || w_timeout) begin
                    w_busErrNxt  = 1'b1;
                end
            end
            STROBE: begin
                w_waitCntNxt = r_waitCnt - WAIT_W'(1);
                if (r_waitCnt == WAIT_W'(1))
                    w_readyNxt = 1'b1;
            end
            HOLD: begin
                if (RD_n && WR_n) begin
                    w_memCsNxt = 1'b0;
                    w_ioCsNxt  = 1'b0;
                    w_oeNxt    = 1'b1;
                    w_wrNxt    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign Address = r_address;
    assign IOM     = r_iom;
    assign MemCS   = r_memCs;
    assign IoCS    = r_ioCs;
    assign OE      = r_oe;
    assign WR      = r_wr;
    assign READY   = r_ready;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Scoreboard bench for bus_cycle_controller; BUS_TIMEOUT_EN enables the timeout checks.
module tb_bus_cycle_controller;

    localparam int NW = 2;

    typedef struct {
        logic [19:0] addr;
        logic        memCs;
        logic        ioCs;
        logic        oe;
        logic        wr;
        int          waits;
    } expect_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ALE = 1'b0;
    logic        IOM_in = 1'b0;
    logic        RD_n = 1'b1;
    logic        WR_n = 1'b1;
    logic [11:0] A_hi = '0;
    logic [7:0]  AD = '0;
    logic [19:0] Address;
    logic        IOM;
    logic        MemCS;
    logic        IoCS;
    logic        OE;
    logic        WR;
    logic        READY;
    logic        BusErr;

    int      tests = 0;
    int      fails = 0;
    expect_t sbQ[$];
    logic    expErr;

    bus_cycle_controller #(.ADDR_WIDTH(20), .NUM_WAIT(NW)) dut (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM_in(IOM_in), .RD_n(RD_n), .WR_n(WR_n),
        .A_hi(A_hi), .AD(AD), .Address(Address), .IOM(IOM), .MemCS(MemCS), .IoCS(IoCS),
        .OE(OE), .WR(WR), .READY(READY), .BusErr(BusErr)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Drive one cycle of inputs just after a falling edge and return at the next falling edge.
    task automatic applyStimulus(input logic rst, input logic ale, input logic iomIn,
                                 input logic rdN, input logic wrN, input logic [19:0] addr);
        #1;
        RESET = rst; ALE = ale; IOM_in = iomIn; RD_n = rdN; WR_n = wrN;
        A_hi = addr[19:8]; AD = addr[7:0];
        @(negedge CLK);
    endtask

    task automatic checkOutput(input string name, input logic [19:0] eAddr, input logic eMem,
                               input logic eIo, input logic eOe, input logic eWr,
                               input logic eRdy, input logic eErr);
        tests++;
        if ({Address, MemCS, IoCS, OE, WR, READY, BusErr} !== {eAddr, eMem, eIo, eOe, eWr, eRdy, eErr}) begin
            fails++;
            $display("[TB] FAIL %s: got addr=%h mem=%b io=%b oe=%b wr=%b rdy=%b err=%b, want addr=%h mem=%b io=%b oe=%b wr=%b rdy=%b err=%b",
                     name, Address, MemCS, IoCS, OE, WR, READY, BusErr, eAddr, eMem, eIo, eOe, eWr, eRdy, eErr);
        end
    endtask

    // Full strobed cycle with an expected completion pushed to the scoreboard.
    task automatic doCycle(input string name, input logic iomIn, input logic isWrite,
                           input logic [19:0] addr, input logic eMem, input logic eIo);
        expect_t e;
        applyStimulus(1'b0, 1'b1, iomIn, 1'b1, 1'b1, addr);
        e.addr = addr; e.memCs = eMem; e.ioCs = eIo; e.oe = isWrite; e.wr = !isWrite; e.waits = NW;
        sbQ.push_back(e);
        applyStimulus(1'b0, 1'b0, 1'b0, isWrite, !isWrite, 20'h0);
        checkOutput({name, "_entry"}, addr, eMem, eIo, isWrite, !isWrite, 1'b0, 1'b0);
        for (int i = 0; i < NW; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, isWrite, !isWrite, 20'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'hFFFFF);
        checkOutput({name, "_release"}, addr, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    // Monitor: a READY rising edge marks a completed cycle; compare against the scoreboard head.
    int   lowCount = 0;
    logic prevReady = 1'b1;
    always @(negedge CLK) begin
        expect_t e;
        if (RESET) begin
            lowCount = 0;
        end else if (READY === 1'b0) begin
            lowCount++;
        end else if (prevReady === 1'b0) begin
            tests++;
            if (sbQ.size() == 0) begin
                fails++;
                $display("[TB] FAIL sb_unexpected: completion at addr=%h, want none", Address);
            end else begin
                e = sbQ.pop_front();
                if ({Address, MemCS, IoCS, OE, WR} !== {e.addr, e.memCs, e.ioCs, e.oe, e.wr}) begin
                    fails++;
                    $display("[TB] FAIL sb_cycle: got addr=%h mem=%b io=%b oe=%b wr=%b, want addr=%h mem=%b io=%b oe=%b wr=%b",
                             Address, MemCS, IoCS, OE, WR, e.addr, e.memCs, e.ioCs, e.oe, e.wr);
                end
                tests++;
                if (lowCount != e.waits) begin
                    fails++;
                    $display("[TB] FAIL sb_waits: got %0d READY-low cycles, want %0d", lowCount, e.waits);
                end
            end
            lowCount = 0;
        end
        prevReady = READY;
    end

    initial begin
        @(negedge CLK);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);
        checkOutput("reset", 20'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);
        checkOutput("idle5", 20'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        doCycle("mem_rd", 1'b0, 1'b0, 20'h01234, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h0);
        checkOutput("no_ale_after_release", 20'h01234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 20'h00100);
        checkOutput("relatch_first", 20'h00100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        doCycle("io_wr", 1'b1, 1'b1, 20'h00085, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);
        doCycle("io_unmapped", 1'b1, 1'b0, 20'h00100, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);
        doCycle("mem_unmapped", 1'b0, 1'b1, 20'h80010, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);

`ifdef BUS_TIMEOUT_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'h02000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0);
        checkOutput("violation", 20'h02000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, expErr);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h0);
        checkOutput("violation_idle", 20'h02000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'h00042);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h0);
        checkOutput("abort_strobe", 20'h00042, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'h0);
        checkOutput("reset_mid_strobe", 20'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);
        doCycle("after_reset", 1'b0, 1'b0, 20'h05678, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);

`ifdef BUS_TIMEOUT_EN
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'h00777);
        for (int i = 0; i < 254; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);
        checkOutput("timeout_before", 20'h00777, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);
        checkOutput("timeout_pulse", 20'h00777, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h0);
        checkOutput("timeout_idle", 20'h00777, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);
`endif

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h0);
        tests++;
        if (sbQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL sb_drain: got %0d pending cycles, want 0", sbQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_cycle_controller.md
Name: bus_cycle_controller

Overview:
- Upstream front end for the 8088 minimum-mode bus, feeding the memory/IO storage modules.
- Latches the multiplexed address on ALE and tracks the bus cycle through a state machine.
- Decodes the latched address to a memory or I/O chip select and generates the active-low OE/WR strobes the storage modules consume.
- Holds READY low for a programmable number of wait states, so the one-cycle-latency storage stage has valid read data before the CPU samples it.
- Data lines stay on AD[7:0]; this block never drives AD.

Parameters:
- ADDR_WIDTH, 20, CPU address width.
- NUM_WAIT, 2, wait states per strobed cycle; legal range 1..15.
- MEM_BASE, 20'h00000, memory region base; compared on bits set in MEM_MASK.
- MEM_MASK, 20'h80000, memory decode mask (512 KiB region).
- IO_BASE, 16'h0080, I/O region base; compared on Address[15:0].
- IO_MASK, 16'hFFF0, I/O decode mask (16 ports).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous reset, active-high.
- ALE  in  1  address latch enable from CPU.
- IOM_in  in  1  CPU IO/M: 0 selects memory, 1 selects I/O.
- RD_n  in  1  CPU read strobe, active low.
- WR_n  in  1  CPU write strobe, active low.
- A_hi  in  ADDR_WIDTH-8  CPU address A[19:8].
- AD  in  8  multiplexed address/data AD[7:0]; sampled only.
- Address  out  ADDR_WIDTH  latched address to storage modules.
- IOM  out  1  latched IO/M.
- MemCS  out  1  memory chip select, active high.
- IoCS  out  1  I/O chip select, active high.
- OE  out  1  output enable, active low.
- WR  out  1  write enable, active low.
- READY  out  1  CPU ready; 0 inserts wait states.
- BusErr  out  1  one-cycle error pulse; only driven with the optional feature.

Behaviour:
- Reset is synchronous; clock is CLK.
- Reset values: Address=0, IOM=0, MemCS=0, IoCS=0, OE=1, WR=1, READY=1, BusErr=0, state=IDLE. RESET in any state returns all of these at the next edge; an in-flight cycle is dropped.
- All outputs are registered.
- States are IDLE, ADDR, STROBE, HOLD.
- IDLE:
  - ALE=1 at an edge: Address<={A_hi,AD} and IOM<=IOM_in at that edge; go to ADDR.
  - Address holds between cycles.
- ADDR:
  - ALE=1 again: relatch the address and stay in ADDR.
  - RD_n=0, WR_n=1: go to STROBE with OE<=0.
  - WR_n=0, RD_n=1: go to STROBE with WR<=0.
  - RD_n=0 and WR_n=0: protocol violation; go to IDLE, no strobe, no CS.
  - Otherwise wait.
- Chip select on entry to STROBE (same edge as the strobe):
  - MemCS<=1 if IOM=0 and (Address&MEM_MASK)==MEM_BASE.
  - IoCS<=1 if IOM=1 and (Address[15:0]&IO_MASK)==IO_BASE.
  - MemCS and IoCS are mutually exclusive.
  - Unmapped cycle: no CS, but strobes, READY and state sequencing are unchanged, so the CPU never hangs.
- STROBE:
  - The wait counter is loaded with NUM_WAIT and READY<=0 at the entry edge.
  - The counter decrements each edge.
  - When the counter reaches 1, the next edge sets READY<=1 and moves to HOLD.
  - READY is therefore low for exactly NUM_WAIT cycles.
  - ALE is ignored in STROBE and HOLD.
- HOLD:
  - CS, strobe and Address are held.
  - When RD_n=1 and WR_n=1 are sampled: MemCS, IoCS <=0, OE, WR <=1, go to IDLE.
  - ALE in the same cycle as strobe release is ignored; the next cycle needs a fresh ALE in IDLE.
- Timing guarantee: CS and strobe are stable for at least NUM_WAIT+1 edges. The storage stage sees CS&&!OE at one edge and drives Data before READY rises.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro:
  - An 8-bit counter runs in ADDR.
  - 255 cycles without a strobe: return to IDLE and pulse BusErr=1 for one cycle.
  - The RD_n=WR_n=0 violation also pulses BusErr.
- Without the macro: BusErr is tied 0 and ADDR waits indefinitely.

Decomposition:
- Package bus_pkg holds:
  - the state enum type bus_state_t (one-hot, 4 bits);
  - the constant WAIT_W=4;
  - the default region base and mask constants.
- One combinational sub-module, bus_region_decode: inputs Address and IOM plus the base/mask parameters; outputs mem_hit and io_hit.
- The controller registers mem_hit and io_hit into MemCS and IoCS.

Test Plan:
1. Reset, then 5 idle cycles -> OE=1, WR=1, MemCS=0, IoCS=0, READY=1, Address=0.
2. Memory read, ALE with A=20'h01234, IOM_in=0, then RD_n=0 -> MemCS=1 and OE=0 on the same edge; READY=0 for exactly 2 cycles; RD_n release -> all deasserted the next edge.
3. I/O write to 16'h0085 with IOM_in=1 and WR_n=0 -> IoCS=1, WR=0, MemCS=0; unmapped I/O 16'h0100 -> strobe, no CS, READY still returns high after 2 cycles.
4. RD_n=0 and WR_n=0 together in ADDR -> back to IDLE, no CS, OE=WR=1; BusErr pulse only if BUS_TIMEOUT_EN.
5. RESET asserted mid-STROBE with NUM_WAIT=5 -> next edge all outputs at reset values; a new ALE cycle works normally.
6. BUS_TIMEOUT_EN: ALE then no strobe for 255 cycles -> BusErr=1 for one cycle, state IDLE; NUM_WAIT=1 build -> READY low for exactly 1 cycle.
